// File: rtl/accel_count_if.sv
// Bus between the accelerometer timing processor / computer side (master)
// and the velocity-increment accumulator (slave).
interface accel_count_if #(
   parameter int unsigned WIDTH = 15
);
   logic             W4;
   logic             CNT_UP;
   logic             CNT_DN;
   logic             HALT;
   logic             RD_REQ;
   logic             SHIFT;
   logic             SER_OUT;
   logic             RD_BUSY;
   logic             RD_DONE;
   logic             OVF;
   logic [WIDTH-1:0] CNT;

   modport master (
      output W4, CNT_UP, CNT_DN, HALT, RD_REQ, SHIFT,
      input  SER_OUT, RD_BUSY, RD_DONE, OVF, CNT
   );

   modport slave (
      input  W4, CNT_UP, CNT_DN, HALT, RD_REQ, SHIFT,
      output SER_OUT, RD_BUSY, RD_DONE, OVF, CNT
   );
endinterface

// File: rtl/accel_count_reg.sv
// Velocity-increment accumulator: counts W4-phase up/down requests, and on read
// snapshots {OVF, CNT} into a shift register and streams it out LSB first.
module accel_count_reg #(
   parameter int unsigned WIDTH = 15
) (
   input  logic        SIM_CLK,
   input  logic        SIM_RST,
   accel_count_if.slave bus
);
   localparam int unsigned BCW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFTING,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt, cnt_base, cnt_nxt;
   logic             ovf;
   logic [WIDTH:0]   sr;
   logic [BCW-1:0]   bit_cnt;
   logic             cnt_en, snap, wrap, last_bit;

   assign cnt_en   = bus.W4 & ~bus.HALT & (bus.CNT_UP ^ bus.CNT_DN);
   assign snap     = (state == IDLE) & bus.RD_REQ;
   assign last_bit = (bit_cnt == BCW'(WIDTH));

   // Snapshot and clear share one edge: the request of that cycle lands on zero.
   assign cnt_base = snap ? '0 : cnt;

   always_comb begin
      cnt_nxt = cnt_base;
      if (cnt_en)
         cnt_nxt = bus.CNT_UP ? cnt_base + WIDTH'(1) : cnt_base - WIDTH'(1);
   end

   // Flags crossings of both the signed (0x3FFF/0x4000) and modulo (0x7FFF/0x0000) boundaries.
   assign wrap = cnt_en & (bus.CNT_UP ? (&cnt[WIDTH-2:0]) : ~(|cnt[WIDTH-2:0]));

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         cnt     <= '0;
         ovf     <= 1'b0;
         sr      <= '0;
         bit_cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (snap)
            ovf <= 1'b0;
         else if (wrap)
            ovf <= 1'b1;

         if (snap) begin
            sr      <= {ovf, cnt};
            bit_cnt <= '0;
         end else if ((state == SHIFTING) && bus.SHIFT) begin
            sr      <= {1'b0, sr[WIDTH:1]};
            bit_cnt <= bit_cnt + BCW'(1);
         end
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.RD_REQ) state_nxt = SHIFTING;
         SHIFTING: if (bus.SHIFT && last_bit) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign bus.SER_OUT = (state == SHIFTING) ? sr[0] : 1'b0;
   assign bus.RD_BUSY = (state == SHIFTING);
   assign bus.RD_DONE = (state == DONE);
   assign bus.OVF     = ovf;
   assign bus.CNT     = cnt;
endmodule

// File: tb/tb_accel_count_reg.sv
// Directed bench for accel_count_reg: table-driven counting vectors plus
// hand-written read, overflow and protocol sequences.
module tb_accel_count_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   accel_count_if #(.WIDTH(15)) bus ();

   accel_count_reg #(.WIDTH(15)) dut (
      .SIM_CLK (clk),
      .SIM_RST (rst_n),
      .bus     (bus)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      int          rep;
      logic        w4;
      logic        up;
      logic        dn;
      logic        halt;
      logic [14:0] cnt;
      logic        ovf;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.W4 = 1'b0; bus.CNT_UP = 1'b0; bus.CNT_DN = 1'b0;
      bus.HALT = 1'b0; bus.RD_REQ = 1'b0; bus.SHIFT = 1'b0;
   endtask

   task automatic count(input int n, input logic up, input logic dn);
      bus.W4 = 1'b1; bus.CNT_UP = up; bus.CNT_DN = dn;
      repeat (n) tick();
      bus.W4 = 1'b0; bus.CNT_UP = 1'b0; bus.CNT_DN = 1'b0;
   endtask

   // Full read with SHIFT held; optional count request on the snapshot edge
   // and on the first n_up shift cycles.
   task automatic read_frame(input string tag, input logic up_at_req, input int n_up,
                             input logic [15:0] exp_frame, input logic [14:0] exp_cnt_req,
                             input logic [14:0] exp_cnt_done);
      logic [15:0] frame;
      int          busy;
      bus.RD_REQ = 1'b1; bus.W4 = up_at_req; bus.CNT_UP = up_at_req;
      tick();
      bus.RD_REQ = 1'b0; bus.W4 = 1'b0; bus.CNT_UP = 1'b0;
      chk({tag, "_busy_start"}, 32'(bus.RD_BUSY), 32'd1);
      chk({tag, "_ovf_clr"}, 32'(bus.OVF), 32'd0);
      chk({tag, "_cnt_snap"}, 32'(bus.CNT), 32'(exp_cnt_req));
      frame = '0;
      busy  = 0;
      bus.SHIFT = 1'b1;
      for (int i = 0; i < 16; i++) begin
         frame[i] = bus.SER_OUT;
         busy += int'(bus.RD_BUSY);
         bus.W4 = (i < n_up); bus.CNT_UP = (i < n_up);
         tick();
      end
      bus.W4 = 1'b0; bus.CNT_UP = 1'b0; bus.SHIFT = 1'b0;
      chk({tag, "_frame"}, 32'(frame), 32'(exp_frame));
      chk({tag, "_busy_cycles"}, 32'(busy), 32'd16);
      chk({tag, "_busy_end"}, 32'(bus.RD_BUSY), 32'd0);
      chk({tag, "_done"}, 32'(bus.RD_DONE), 32'd1);
      chk({tag, "_ser_done"}, 32'(bus.SER_OUT), 32'd0);
      chk({tag, "_cnt_done"}, 32'(bus.CNT), 32'(exp_cnt_done));
      tick();
      chk({tag, "_done_pulse"}, 32'(bus.RD_DONE), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cnt"}, 32'(bus.CNT), 32'd0);
      chk({tag, "_ovf"}, 32'(bus.OVF), 32'd0);
      chk({tag, "_busy"}, 32'(bus.RD_BUSY), 32'd0);
      chk({tag, "_done"}, 32'(bus.RD_DONE), 32'd0);
      chk({tag, "_ser"}, 32'(bus.SER_OUT), 32'd0);
   endtask

   initial begin
      vecs[0] = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd10, 1'b0};
      vecs[1] = '{ 3, 1'b1, 1'b0, 1'b1, 1'b0, 15'd7,  1'b0};
      vecs[2] = '{ 5, 1'b0, 1'b1, 1'b0, 1'b0, 15'd7,  1'b0};
      vecs[3] = '{ 5, 1'b1, 1'b1, 1'b0, 1'b1, 15'd7,  1'b0};
      vecs[4] = '{ 1, 1'b1, 1'b1, 1'b1, 1'b0, 15'd7,  1'b0};
      vecs[5] = '{ 2, 1'b1, 1'b0, 1'b1, 1'b1, 15'd7,  1'b0};
      vecs[6] = '{ 4, 1'b0, 1'b0, 1'b1, 1'b0, 15'd7,  1'b0};
      vecs[7] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b0, 15'd6,  1'b0};
      vecs[8] = '{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 15'd7,  1'b0};

      idle_inputs();
      tick();
      tick();
      chk_all_zero("reset_state");
      rst_n = 1'b1;

      // Asynchronous reset while counting
      count(15'h122, 1'b1, 1'b0);
      bus.W4 = 1'b1; bus.CNT_UP = 1'b1;
      tick();
      chk("pre_reset_cnt", 32'(bus.CNT), 32'h123);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      idle_inputs();
      tick();
      rst_n = 1'b1;

      // Counting vectors
      for (int v = 0; v < 9; v++) begin
         bus.W4 = vecs[v].w4; bus.CNT_UP = vecs[v].up;
         bus.CNT_DN = vecs[v].dn; bus.HALT = vecs[v].halt;
         repeat (vecs[v].rep) tick();
         idle_inputs();
         chk($sformatf("vec%0d_cnt", v), 32'(bus.CNT), 32'(vecs[v].cnt));
         chk($sformatf("vec%0d_ovf", v), 32'(bus.OVF), 32'(vecs[v].ovf));
      end

      // Plain reads
      read_frame("rd7", 1'b0, 0, 16'h0007, 15'd0, 15'd0);
      count(37, 1'b1, 1'b0);
      read_frame("rd25", 1'b0, 0, 16'h0025, 15'd0, 15'd0);

      // Count request on the snapshot edge, counting during the shift
      count(16, 1'b1, 1'b0);
      read_frame("simul", 1'b1, 4, 16'h0010, 15'd1, 15'd5);

      // Overflow boundaries
      read_frame("clr5", 1'b0, 0, 16'h0005, 15'd0, 15'd0);
      count(15'h3FFF, 1'b1, 1'b0);
      chk("cnt_3fff", 32'(bus.CNT), 32'h3FFF);
      chk("ovf_3fff", 32'(bus.OVF), 32'd0);
      count(1, 1'b1, 1'b0);
      chk("cnt_4000", 32'(bus.CNT), 32'h4000);
      chk("ovf_4000", 32'(bus.OVF), 32'd1);
      read_frame("wrap", 1'b0, 0, 16'hC000, 15'd0, 15'd0);
      count(1, 1'b0, 1'b1);
      chk("cnt_7fff", 32'(bus.CNT), 32'h7FFF);
      chk("ovf_7fff", 32'(bus.OVF), 32'd1);
      count(1, 1'b1, 1'b0);
      chk("cnt_wrap0", 32'(bus.CNT), 32'h0000);
      chk("ovf_sticky", 32'(bus.OVF), 32'd1);
      read_frame("ovf_only", 1'b0, 0, 16'h8000, 15'd0, 15'd0);

      // Protocol: RD_REQ ignored mid-frame, SHIFT pause, reset at bit 8
      count(16'h5A, 1'b1, 1'b0);
      bus.RD_REQ = 1'b1;
      tick();
      bus.RD_REQ = 1'b0;
      chk("proto_bit0", 32'(bus.SER_OUT), 32'd0);
      bus.SHIFT = 1'b1;
      repeat (3) tick();
      bus.SHIFT = 1'b0;
      chk("proto_bit3", 32'(bus.SER_OUT), 32'd1);
      count(3, 1'b1, 1'b0);
      bus.RD_REQ = 1'b1;
      tick();
      bus.RD_REQ = 1'b0;
      chk("proto_rdreq_cnt", 32'(bus.CNT), 32'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("proto_hold%0d", i), 32'(bus.SER_OUT), 32'd1);
      end
      chk("proto_busy_hold", 32'(bus.RD_BUSY), 32'd1);
      bus.SHIFT = 1'b1;
      tick();
      chk("proto_bit4", 32'(bus.SER_OUT), 32'd1);
      repeat (4) tick();
      bus.SHIFT = 1'b0;
      chk("proto_bit8", 32'(bus.SER_OUT), 32'd0);
      chk("proto_busy_bit8", 32'(bus.RD_BUSY), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midframe_reset");
      tick();
      rst_n = 1'b1;
      begin
         int done_seen;
         done_seen = 0;
         for (int i = 0; i < 20; i++) begin
            tick();
            done_seen += int'(bus.RD_DONE) + int'(bus.RD_BUSY);
         end
         chk("no_done_after_reset", 32'(done_seen), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
